// File: rtl/pipeline_exec_ctrl.sv
// Execution controller: program load, continuous/step run, drain and
// debug dump of PC, register file and data memory over valid/ready.
module pipeline_exec_ctrl #(
  parameter int INST_SZ      = 32,
  parameter int PC_SZ        = 32,
  parameter int DBG_ADDR_SZ  = 5,
  parameter int NUM_REGS     = 32,
  parameter int NUM_MEM      = 32,
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_SZ       = 32
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_load_start,
  input  logic                   i_load_valid,
  input  logic                   i_load_last,
  input  logic [INST_SZ-1:0]     i_load_word,
  output logic                   o_load_ready,
  input  logic                   i_mode,
  input  logic                   i_start,
  input  logic                   i_step,
  input  logic                   i_halt,
  input  logic [PC_SZ-1:0]       i_pc,
  input  logic [INST_SZ-1:0]     i_reg_data,
  input  logic [INST_SZ-1:0]     i_mem_data,
  output logic                   o_write,
  output logic                   o_enable,
  output logic [INST_SZ-1:0]     o_instruction,
  output logic [DBG_ADDR_SZ-1:0] o_debug_addr,
  output logic                   o_dump_valid,
  output logic [INST_SZ-1:0]     o_dump_data,
  output logic                   o_dump_last,
  input  logic                   i_dump_ready,
  output logic [2:0]             o_state,
  output logic [CNT_SZ-1:0]      o_cycle_count,
  output logic                   o_busy
);

  localparam int TOT    = NUM_REGS + NUM_MEM + 1;
  localparam int IDX_SZ = $clog2(TOT + 1);
  localparam int DRN_SZ = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    STEP  = 3'd3,
    DRAIN = 3'd4,
    DUMP  = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t state, nxt;

  logic                   step_pend;
  logic                   step_halt;
  logic                   from_step;
  logic [DRN_SZ-1:0]      drain_cnt;
  logic [IDX_SZ-1:0]      idx;
  logic [IDX_SZ-1:0]      idx_n;
  logic                   wait_q;
  logic                   dump_valid;
  logic                   dump_last;
  logic [INST_SZ-1:0]     dump_data;
  logic [INST_SZ-1:0]     dump_sel;
  logic [DBG_ADDR_SZ-1:0] dbg_addr;
  logic [DBG_ADDR_SZ-1:0] addr_n;
  logic                   write_q;
  logic [INST_SZ-1:0]     instr_q;
  logic [CNT_SZ-1:0]      cyc;

  logic accept;
  logic dump_hs;
  logic dump_end;
  logic drain_end;
  logic en;
  logic run_entry;
  logic dump_entry;

  assign accept    = (state == LOAD) && i_load_valid;
  assign dump_hs   = dump_valid && i_dump_ready;
  assign dump_end  = dump_hs && dump_last;
  assign drain_end = (state == DRAIN) &&
                     (drain_cnt == DRN_SZ'(DRAIN_CYCLES - 1));

  assign en = (state == RUN) || (state == DRAIN) ||
              ((state == STEP) && step_pend);

  assign run_entry  = (state == IDLE) &&
                      ((nxt == RUN) || (nxt == STEP));
  assign dump_entry = (state != DUMP) && (nxt == DUMP);

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (i_load_start)
          nxt = LOAD;
        else if (i_start)
          nxt = i_mode ? STEP : RUN;
      end
      LOAD: begin
        if (accept && i_load_last)
          nxt = IDLE;
      end
      RUN: begin
        if (i_halt)
          nxt = DRAIN;
      end
      STEP: begin
        if (step_pend)
          nxt = DUMP;
      end
      DRAIN: begin
        if (drain_end)
          nxt = DUMP;
      end
      DUMP: begin
        if (dump_end) begin
          if (!from_step)
            nxt = DONE;
          else if (step_halt)
            nxt = DRAIN;
          else
            nxt = STEP;
        end
      end
      DONE: begin
        if (i_start || i_load_start)
          nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)
      state <= IDLE;
    else
      state <= nxt;
  end

  // Index 0 is the PC, then the register file, then data memory.
  assign idx_n = idx + IDX_SZ'(1);

  always_comb begin
    addr_n = '0;
    if (idx_n <= IDX_SZ'(NUM_REGS))
      addr_n = DBG_ADDR_SZ'(idx_n - IDX_SZ'(1));
    else
      addr_n = DBG_ADDR_SZ'(idx_n - IDX_SZ'(NUM_REGS + 1));
  end

  always_comb begin
    dump_sel = i_mem_data;
    if (idx == '0)
      dump_sel = INST_SZ'(i_pc);
    else if (idx <= IDX_SZ'(NUM_REGS))
      dump_sel = i_reg_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      write_q <= 1'b0;
      instr_q <= '0;
    end else begin
      write_q <= accept;
      if (accept)
        instr_q <= i_load_word;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)
      cyc <= '0;
    else if (run_entry)
      cyc <= '0;
    else if (en && (cyc != '1))
      cyc <= cyc + CNT_SZ'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      step_pend <= 1'b0;
      step_halt <= 1'b0;
    end else if (state == IDLE) begin
      step_pend <= 1'b0;
      step_halt <= 1'b0;
    end else if (state == STEP) begin
      if (step_pend) begin
        step_pend <= 1'b0;
        step_halt <= i_halt;
      end else if (i_step) begin
        step_pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)
      drain_cnt <= '0;
    else if (state == DRAIN)
      drain_cnt <= drain_cnt + DRN_SZ'(1);
    else
      drain_cnt <= '0;
  end

  // Each word: address out, one wait cycle for the read, then capture.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      idx        <= '0;
      dbg_addr   <= '0;
      wait_q     <= 1'b0;
      dump_valid <= 1'b0;
      dump_last  <= 1'b0;
      dump_data  <= '0;
      from_step  <= 1'b0;
    end else if (dump_entry) begin
      idx        <= '0;
      dbg_addr   <= '0;
      wait_q     <= 1'b1;
      dump_valid <= 1'b0;
      dump_last  <= 1'b0;
      from_step  <= (state == STEP);
    end else if (state == DUMP) begin
      if (dump_hs) begin
        dump_valid <= 1'b0;
        dump_last  <= 1'b0;
        if (!dump_last) begin
          idx      <= idx_n;
          dbg_addr <= addr_n;
          wait_q   <= 1'b1;
        end
      end else if (wait_q) begin
        wait_q <= 1'b0;
      end else if (!dump_valid) begin
        dump_valid <= 1'b1;
        dump_data  <= dump_sel;
        dump_last  <= (idx == IDX_SZ'(TOT - 1));
      end
    end
  end

  assign o_load_ready  = (state == LOAD);
  assign o_write       = write_q;
  assign o_instruction = instr_q;
  assign o_enable      = en;
  assign o_debug_addr  = dbg_addr;
  assign o_dump_valid  = dump_valid;
  assign o_dump_data   = dump_data;
  assign o_dump_last   = dump_last;
  assign o_state       = state;
  assign o_cycle_count = cyc;
  assign o_busy        = (state == LOAD) || (state == RUN) ||
                         (state == DRAIN) || (state == DUMP);

endmodule

// File: tb/tb_pipeline_exec_ctrl.sv
// Directed bench for pipeline_exec_ctrl: load, run/drain, dump,
// step mode and reset during a dump.
module tb_pipeline_exec_ctrl;

  logic        i_clk;
  logic        i_reset;
  logic        i_load_start;
  logic        i_load_valid;
  logic        i_load_last;
  logic [31:0] i_load_word;
  logic        o_load_ready;
  logic        i_mode;
  logic        i_start;
  logic        i_step;
  logic        i_halt;
  logic [31:0] i_pc;
  logic [31:0] i_reg_data;
  logic [31:0] i_mem_data;
  logic        o_write;
  logic        o_enable;
  logic [31:0] o_instruction;
  logic [4:0]  o_debug_addr;
  logic        o_dump_valid;
  logic [31:0] o_dump_data;
  logic        o_dump_last;
  logic        i_dump_ready;
  logic [2:0]  o_state;
  logic [31:0] o_cycle_count;
  logic        o_busy;

  int vectors = 0;
  int errs    = 0;
  int en_cnt  = 0;
  int en_base;

  logic [31:0] reg_q;
  logic [31:0] mem_q;

  pipeline_exec_ctrl dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_load_start  (i_load_start),
    .i_load_valid  (i_load_valid),
    .i_load_last   (i_load_last),
    .i_load_word   (i_load_word),
    .o_load_ready  (o_load_ready),
    .i_mode        (i_mode),
    .i_start       (i_start),
    .i_step        (i_step),
    .i_halt        (i_halt),
    .i_pc          (i_pc),
    .i_reg_data    (i_reg_data),
    .i_mem_data    (i_mem_data),
    .o_write       (o_write),
    .o_enable      (o_enable),
    .o_instruction (o_instruction),
    .o_debug_addr  (o_debug_addr),
    .o_dump_valid  (o_dump_valid),
    .o_dump_data   (o_dump_data),
    .o_dump_last   (o_dump_last),
    .i_dump_ready  (i_dump_ready),
    .o_state       (o_state),
    .o_cycle_count (o_cycle_count),
    .o_busy        (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Pipeline debug taps with one cycle of read latency.
  always @(posedge i_clk) begin
    reg_q <= 32'hA000_0000 | {27'd0, o_debug_addr};
    mem_q <= 32'hB000_0000 | {27'd0, o_debug_addr};
    if (o_enable)
      en_cnt <= en_cnt + 1;
  end
  assign i_reg_data = reg_q;
  assign i_mem_data = mem_q;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int k);
    if (k == 0)
      return 32'h0000_1234;
    else if (k <= 32)
      return 32'hA000_0000 + 32'(k - 1);
    else
      return 32'hB000_0000 + 32'(k - 33);
  endfunction

  task automatic dump_collect(input bit toggle, input int nwords);
    int          words = 0;
    bit          stalled = 0;
    logic [31:0] held = '0;
    logic        held_last = 1'b0;
    for (int c = 0; c < 3000 && words < nwords; c++) begin
      i_dump_ready = toggle ? (c % 2 == 0) : 1'b1;
      chk("dump_enable_low", o_enable, 0);
      if (stalled) begin
        chk("hold_valid", o_dump_valid, 1);
        chk("hold_data", o_dump_data, held);
        chk("hold_last", o_dump_last, held_last);
      end
      if (o_dump_valid) begin
        if (i_dump_ready) begin
          chk($sformatf("dump_word%0d", words), o_dump_data,
              exp_word(words));
          chk($sformatf("dump_last%0d", words), o_dump_last,
              words == 64);
          words++;
          stalled = 0;
        end else begin
          stalled   = 1;
          held      = o_dump_data;
          held_last = o_dump_last;
        end
      end
      tick();
    end
    i_dump_ready = 1'b0;
    chk("dump_count", words, nwords);
  endtask

  logic [31:0] words_in [3];

  initial begin
    words_in[0] = 32'h0010_0093;
    words_in[1] = 32'h0020_8113;
    words_in[2] = 32'hFFFF_FFFF;
    i_reset      = 1'b1;
    i_load_start = 1'b0;
    i_load_valid = 1'b0;
    i_load_last  = 1'b0;
    i_load_word  = '0;
    i_mode       = 1'b0;
    i_start      = 1'b0;
    i_step       = 1'b0;
    i_halt       = 1'b0;
    i_pc         = 32'h0000_1234;
    i_dump_ready = 1'b0;
    tick();
    tick();
    chk("rst_state", o_state, 0);
    chk("rst_write", o_write, 0);
    chk("rst_enable", o_enable, 0);
    chk("rst_dump_valid", o_dump_valid, 0);
    chk("rst_count", o_cycle_count, 0);
    chk("rst_addr", o_debug_addr, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_load_ready", o_load_ready, 0);
    i_reset = 1'b0;
    tick();

    // Load wins over start
    i_load_start = 1'b1;
    i_start      = 1'b1;
    tick();
    i_load_start = 1'b0;
    i_start      = 1'b0;
    chk("both_start_state", o_state, 1);
    chk("load_ready", o_load_ready, 1);
    chk("load_busy", o_busy, 1);
    chk("load_no_enable", o_enable, 0);

    i_load_valid = 1'b1;
    i_load_word  = words_in[0];
    tick();
    chk("w0_write", o_write, 1);
    chk("w0_instr", o_instruction, words_in[0]);
    i_load_valid = 1'b0;
    tick();
    chk("gap_write", o_write, 0);
    i_load_valid = 1'b1;
    i_load_word  = words_in[1];
    tick();
    chk("w1_write", o_write, 1);
    chk("w1_instr", o_instruction, words_in[1]);
    i_load_word = words_in[2];
    i_load_last = 1'b1;
    tick();
    i_load_valid = 1'b0;
    i_load_last  = 1'b0;
    chk("w2_write", o_write, 1);
    chk("w2_instr", o_instruction, words_in[2]);
    chk("load_end_state", o_state, 0);
    tick();
    chk("post_load_write", o_write, 0);
    chk("post_load_state", o_state, 0);

    // Continuous run, halt seen in the 10th enabled cycle
    i_mode  = 1'b0;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    en_base = en_cnt;
    chk("run_state", o_state, 2);
    chk("run_count_clear", o_cycle_count, 0);
    chk("run_enable", o_enable, 1);
    chk("run_busy", o_busy, 1);
    repeat (9) tick();
    i_halt = 1'b1;
    tick();
    i_halt = 1'b0;
    chk("drain_state", o_state, 4);
    for (int c = 0; c < 20 && o_state != 3'd5; c++)
      tick();
    chk("dump_state", o_state, 5);
    chk("run_drain_enables", en_cnt - en_base, 14);
    chk("run_cycle_count", o_cycle_count, 14);
    chk("dump_no_enable", o_enable, 0);

    dump_collect(1'b1, 65);
    chk("done_state", o_state, 6);
    chk("done_busy", o_busy, 0);
    chk("done_valid", o_dump_valid, 0);
    chk("dump_enables", en_cnt - en_base, 14);
    tick();
    chk("done_hold", o_state, 6);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("done_to_idle", o_state, 0);

    // Step mode, two single-cycle steps
    i_mode  = 1'b1;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("step_state", o_state, 3);
    chk("step_count_clear", o_cycle_count, 0);
    chk("step_busy", o_busy, 0);
    for (int s = 0; s < 2; s++) begin
      en_base = en_cnt;
      tick();
      chk("step_idle_enable", o_enable, 0);
      i_step = 1'b1;
      tick();
      chk("step_pulse_enable", o_enable, 1);
      tick();
      i_step = 1'b0;
      chk("step_to_dump", o_state, 5);
      chk("step_enable_off", o_enable, 0);
      dump_collect(1'b0, 65);
      chk("step_return", o_state, 3);
      chk("step_one_enable", en_cnt - en_base, 1);
      chk("step_count", o_cycle_count, s + 1);
    end

    // Reset in the middle of a dump
    i_step = 1'b1;
    tick();
    i_step = 1'b0;
    tick();
    chk("step3_dump", o_state, 5);
    dump_collect(1'b0, 20);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    chk("mid_rst_state", o_state, 0);
    chk("mid_rst_valid", o_dump_valid, 0);
    chk("mid_rst_count", o_cycle_count, 0);
    i_dump_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("post_rst_valid", o_dump_valid, 0);
      chk("post_rst_write", o_write, 0);
    end
    chk("post_rst_state", o_state, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
